// File: rtl/soc_cpu_dct_packer.sv
// Packs 2-bit trace symbols into 30-bit DCT words with a symbol count and
// presents each word through a one-stage valid/ready output register.
module soc_cpu_dct_packer #(
  parameter int unsigned SLOT_W = 2,
  parameter int unsigned SLOTS  = 15,
  parameter int unsigned BUF_W  = 30,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sym_valid,
  input  logic [SLOT_W-1:0] sym_data,
  output logic              sym_ready,
  input  logic              flush,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              dct_valid,
  input  logic              dct_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SLOTS);

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   acc_cnt, acc_cnt_d;
  logic               flush_pend, flush_pend_d;

  logic               load_ok;
  logic               sym_fire;
  logic               flush_eff;
  logic [CNT_W-1:0]   next_cnt;
  logic [BUF_W-1:0]   next_acc;
  logic               xfer;
  logic [BUF_W-1:0]   xfer_word;
  logic [CNT_W-1:0]   xfer_cnt;

  // Accumulator state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      acc_cnt    <= '0;
      flush_pend <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      acc_cnt    <= acc_cnt_d;
      flush_pend <= flush_pend_d;
    end
  end

  // Next-state: accumulate, decide transfer, track a flush that must wait
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    acc_cnt_d    = acc_cnt;
    flush_pend_d = flush_pend;
    xfer         = 1'b0;
    xfer_word    = acc_q;
    xfer_cnt     = acc_cnt;
    flush_eff    = flush | flush_pend;
    next_cnt     = acc_cnt + CNT_W'(sym_fire);
    next_acc     = acc_q;
    if (sym_fire) begin
      next_acc = acc_q | (BUF_W'(sym_data) << (SLOT_W * acc_cnt));
    end

    if (state_q == ST_FULL) begin
      // A full word leaves first; a same-cycle symbol restarts at slot 0
      if (load_ok) begin
        xfer         = 1'b1;
        xfer_word    = acc_q;
        xfer_cnt     = CNT_FULL;
        acc_d        = sym_fire ? BUF_W'(sym_data) : '0;
        acc_cnt_d    = sym_fire ? CNT_W'(1) : '0;
        flush_pend_d = 1'b0;
        state_d      = sym_fire ? ST_FILL : ST_IDLE;
      end else begin
        flush_pend_d = flush_pend | flush;
      end
    end else if ((next_cnt != '0) && ((next_cnt == CNT_FULL) || flush_eff)) begin
      if (load_ok) begin
        xfer         = 1'b1;
        xfer_word    = next_acc;
        xfer_cnt     = next_cnt;
        acc_d        = '0;
        acc_cnt_d    = '0;
        flush_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end else begin
        acc_d        = next_acc;
        acc_cnt_d    = next_cnt;
        flush_pend_d = flush_eff;
        state_d      = (next_cnt == CNT_FULL) ? ST_FULL : ST_FILL;
      end
    end else begin
      acc_d     = next_acc;
      acc_cnt_d = next_cnt;
      state_d   = (next_cnt == '0) ? ST_IDLE : ST_FILL;
    end
  end

  // Handshake and status outputs
  always_comb begin
    load_ok   = !dct_valid | dct_ready;
    sym_ready = (state_q != ST_FULL) | load_ok;
    sym_fire  = sym_valid & sym_ready;
    busy      = (acc_cnt != '0) | dct_valid | flush_pend;
  end

  // Output register: holds while stalled, clears once consumed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_buffer <= '0;
      dct_count  <= '0;
      dct_valid  <= 1'b0;
    end else if (xfer) begin
      dct_buffer <= xfer_word;
      dct_count  <= xfer_cnt;
      dct_valid  <= 1'b1;
    end else if (dct_valid && dct_ready) begin
      dct_buffer <= '0;
      dct_count  <= '0;
      dct_valid  <= 1'b0;
    end
  end

endmodule
